// File: rtl/datareg_pkg.sv
// Opcodes, FSM state encoding and default settle time shared by the
// command-byte register-file loader and its bench.
package datareg_pkg;

   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_WRITE    = 2'b01,
      OP_SELECT   = 2'b10,
      OP_READBACK = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_WR     = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   localparam int SETTLE_DEFAULT = 2;

   function automatic op_e cmd_op(input logic [7:0] cmd);
      return op_e'(cmd[7:6]);
   endfunction

endpackage

// File: rtl/datareg_loader.sv
// Byte-stream command decoder driving a 4x8 register file: writes, read-select
// updates and settled {Da, Db} readback behind a valid/ready response port.
module datareg_loader
   import datareg_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic [7:0]  D,
   output logic [1:0]  addr,
   output logic        WE,
   output logic [1:0]  cha,
   output logic [1:0]  chb,
   input  logic [7:0]  Da,
   input  logic [7:0]  Db,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [7:0]  frames
);

   // Counter value on which the read mux is considered settled.
   localparam logic [1:0] SETTLE_LAST = 2'(SETTLE);

   state_e      r_state;
   logic [1:0]  r_cnt;
   logic [7:0]  r_d;
   logic [1:0]  r_addr;
   logic        r_we;
   logic [1:0]  r_cha;
   logic [1:0]  r_chb;
   logic        r_out_valid;
   logic [15:0] r_out_data;
   logic [7:0]  r_frames;

   logic        w_in_ready;
   logic        w_accept;
   op_e         w_op;

   assign w_in_ready = rst_n && ((r_state == ST_IDLE) || (r_state == ST_DATA));
   assign w_accept   = in_valid && w_in_ready;
   assign w_op       = cmd_op(in_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 2'd0;
         r_d         <= 8'd0;
         r_addr      <= 2'd0;
         r_we        <= 1'b0;
         r_cha       <= 2'd0;
         r_chb       <= 2'd0;
         r_out_valid <= 1'b0;
         r_out_data  <= 16'd0;
         r_frames    <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  unique case (w_op)
                     OP_NOP: begin
                        r_frames <= r_frames + 8'd1;
                     end
                     OP_WRITE: begin
                        r_addr  <= in_data[5:4];
                        r_state <= ST_DATA;
                     end
                     OP_SELECT: begin
                        r_cha    <= in_data[3:2];
                        r_chb    <= in_data[1:0];
                        r_frames <= r_frames + 8'd1;
                     end
                     OP_READBACK: begin
                        r_cha   <= in_data[3:2];
                        r_chb   <= in_data[1:0];
                        r_cnt   <= 2'd0;
                        r_state <= ST_SETTLE;
                     end
                  endcase
               end
            end

            ST_DATA: begin
               if (w_accept) begin
                  r_d     <= in_data;
                  r_we    <= 1'b1;
                  r_state <= ST_WR;
               end
            end

            ST_WR: begin
               r_we     <= 1'b0;
               r_frames <= r_frames + 8'd1;
               r_state  <= ST_IDLE;
            end

            // Selects changed on entry; wait SETTLE edges before sampling Da/Db.
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_out_data  <= {Da, Db};
                  r_out_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end

            ST_RESP: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_frames    <= r_frames + 8'd1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_we        <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign D         = r_d;
   assign addr      = r_addr;
   assign WE        = r_we;
   assign cha       = r_cha;
   assign chb       = r_chb;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign frames    = r_frames;

endmodule
